traffic_gen_multi: RTL
======================

Name: traffic_gen_multi

Overview:
- Parametrised successor to the single-stream router traffic generator.
- Emits complete wormhole packets (head/body/tail flits) into one router input port under on/off flow control.
- Supports configurable packet length, packet count, inter-packet gap and three destination modes (fixed, LFSR-random, round-robin).
- Drives router i_flit/i_transmit_req and samples router o_on_off; used as stimulus source in router and mesh benches.

Parameters:
FLIT_W, 32, flit width in bits (matches router_pkg FLIT_SIZE)
DEST_W, 4, destination/source address field width
NUM_DEST, 16, number of valid destination addresses (≤ 2**DEST_W)
LEN_W, 4, width of packet-length input
CNT_W, 16, width of packet counters
GAP_CYCLES, 2, idle cycles inserted between packets
SEED, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
i_start  in  1  level enable; run while high
i_mode  in  2  0 fixed dest, 1 LFSR dest, 2 round-robin, 3 reserved (treated as 0)
i_dest  in  DEST_W  fixed destination (mode 0)
i_src_addr  in  DEST_W  own node address, placed in head flit
i_pkt_len  in  LEN_W  flits per packet; 0 treated as 1
i_num_pkts  in  CNT_W  packets to send; 0 = unlimited
i_on_off  in  1  downstream on/off credit; 1 = may send
o_flit  out  FLIT_W  registered flit
o_transmit  out  1  registered flit-valid
o_busy  out  1  high outside IDLE/DONE
o_done  out  1  quota reached
o_pkt_count  out  CNT_W  completed packets (tail flit emitted)

Behaviour:
- Reset: async assert, sync deassert handled upstream. All outputs 0, state IDLE, LFSR=SEED, rr pointer 0.
- Flit type field: bits [FLIT_W-1:FLIT_W-2] = 01 head, 00 body, 10 tail, 11 single (head+tail).
- Head fields, MSB-down below type: dest (DEST_W), src (DEST_W), sequence = o_pkt_count low 8 bits, remainder 0.
- Body/tail payload: LFSR value zero-extended/truncated to FLIT_W-2.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances once per emitted body/tail flit and once per LFSR-mode dest selection.
- FSM states:
  - IDLE: i_start=1 at edge -> LOAD.
  - LOAD: latch len (0→1), mode, dest; select dest -> SEND. Mode 1 uses LFSR mod NUM_DEST. Mode 2 uses pointer, then pointer+1 mod NUM_DEST, skipping i_src_addr.
  - SEND: beat counter 0..len-1. On each edge with i_on_off=1, register next flit, o_transmit<=1, beat++. With i_on_off=0, o_transmit<=0 and flit held. After last beat: o_pkt_count++ -> GAP. If GAP_CYCLES=0 -> check directly.
  - GAP: count GAP_CYCLES cycles, o_transmit=0. Then: quota met (i_num_pkts≠0 and count==i_num_pkts) -> DONE; else i_start=1 -> LOAD; else IDLE.
  - DONE: o_done=1, o_transmit=0; i_start=0 -> IDLE, o_done cleared, o_pkt_count cleared.
- Latency: start sampled at edge T0; LOAD at T1; head valid after T2 if i_on_off=1.
- o_transmit is never high for two flits with the same beat; every o_transmit=1 cycle is one accepted transfer (router on/off threshold absorbs one-cycle latency).
- i_start falling mid-packet: packet completes through tail; no truncation.
- Config inputs change mid-packet: ignored until next LOAD.
- o_pkt_count saturates at all-ones in unlimited mode.
- Reset mid-packet: immediate return to reset values; a partial packet is acceptable and the bench must reset the router too.

Test Plan:
- Mode 0, dest=5, src=2, len=4, num=3, on_off=1: 12 flits with types 01,00,00,10 repeating; head dest=5, src=2, seq 0,1,2; 2 idle cycles between packets; o_done=1, o_pkt_count=3.
- len=0 and len=1, num=2: two single flits of type 11, o_transmit high for exactly 1 cycle each.
- len=4, on_off toggles 1,0,0,1,1,0,1: flits advance only on on_off=1 edges; total 4 transfers; no duplicated or skipped beat.
- Mode 2, src=0, NUM_DEST=4, len=1, num=6: head dests 1,2,3,1,2,3.
- i_start dropped after head of an 8-flit packet: remaining 7 flits still sent, then IDLE, o_busy=0, o_done=0.
- reset_n pulsed low mid-body: all outputs 0 asynchronously; LFSR back to 16'hACE1; the next run reproduces an identical payload sequence.

Source files
------------

// File: rtl/traffic_gen_multi.sv
// traffic_gen_multi: wormhole packet source for one router input port.
// Ports: clk, reset_n; i_start/i_mode/i_dest/i_src_addr/i_pkt_len/i_num_pkts
// config; i_on_off credit; o_flit/o_transmit out; o_busy/o_done/o_pkt_count.
module traffic_gen_multi #(
    parameter int FLIT_W = 32,
    parameter int DEST_W = 4,
    parameter int NUM_DEST = 16,
    parameter int LEN_W = 4,
    parameter int CNT_W = 16,
    parameter int GAP_CYCLES = 2,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [DEST_W-1:0] i_dest,
    input  logic [DEST_W-1:0] i_src_addr,
    input  logic [LEN_W-1:0]  i_pkt_len,
    input  logic [CNT_W-1:0]  i_num_pkts,
    input  logic              i_on_off,
    output logic [FLIT_W-1:0] o_flit,
    output logic              o_transmit,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_pkt_count
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST =
        GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [DEST_W-1:0] DEST_MAX = DEST_W'(NUM_DEST - 1);

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [FLIT_W-1:0] flit_q, flit_d;
    logic              tx_q, tx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [DEST_W-1:0] ptr_q, ptr_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [DEST_W-1:0] src_q, src_d;
    logic [CNT_W-1:0]  num_q, num_d;

    logic [15:0]       lfsr_nxt;
    logic [DEST_W-1:0] rr_cand;
    logic [CNT_W-1:0]  cnt_sat;
    logic              last_beat;
    logic [FLIT_W-1:0] cur_flit;

    // Fibonacci taps 16,14,13,11.
    assign lfsr_nxt = {lfsr_q[14:0],
                       lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    function automatic logic [DEST_W-1:0] ptr_inc(
        input logic [DEST_W-1:0] p
    );
        return (p >= DEST_MAX) ? '0 : p + 1'b1;
    endfunction

    function automatic state_t after_pkt(
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] num,
        input logic             start
    );
        if ((num != '0) && (cnt >= num))
            return S_DONE;
        else if (start)
            return S_LOAD;
        else
            return S_IDLE;
    endfunction

    // Never hand out our own address as a round-robin destination.
    assign rr_cand = (ptr_q == i_src_addr) ? ptr_inc(ptr_q) : ptr_q;

    assign cnt_sat = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign last_beat = (beat_q == len_q - 1'b1);

    always_comb begin
        cur_flit = '0;
        if (beat_q == '0) begin
            cur_flit[FLIT_W-1 -: 2] = (len_q == LEN_W'(1)) ? T_SINGLE : T_HEAD;
            cur_flit[FLIT_W-3 -: DEST_W] = dest_q;
            cur_flit[FLIT_W-3-DEST_W -: DEST_W] = src_q;
            cur_flit[FLIT_W-3-2*DEST_W -: 8] = cnt_q[7:0];
        end else begin
            cur_flit[FLIT_W-1 -: 2] = last_beat ? T_TAIL : T_BODY;
            cur_flit[FLIT_W-3:0] = (FLIT_W-2)'(lfsr_q);
        end
    end

    always_comb begin
        state_d = state_q;
        flit_d  = flit_q;
        tx_d    = 1'b0;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        len_d   = len_q;
        gap_d   = gap_q;
        lfsr_d  = lfsr_q;
        ptr_d   = ptr_q;
        dest_d  = dest_q;
        src_d   = src_q;
        num_d   = num_q;
        unique case (state_q)
            S_IDLE: begin
                if (i_start)
                    state_d = S_LOAD;
            end
            S_LOAD: begin
                len_d  = (i_pkt_len == '0) ? LEN_W'(1) : i_pkt_len;
                src_d  = i_src_addr;
                num_d  = i_num_pkts;
                beat_d = '0;
                unique case (i_mode)
                    2'd1: begin
                        dest_d = DEST_W'(32'(lfsr_q) % NUM_DEST);
                        lfsr_d = lfsr_nxt;
                    end
                    2'd2: begin
                        dest_d = rr_cand;
                        ptr_d  = ptr_inc(rr_cand);
                    end
                    default: dest_d = i_dest;
                endcase
                state_d = S_SEND;
            end
            S_SEND: begin
                if (i_on_off) begin
                    tx_d   = 1'b1;
                    flit_d = cur_flit;
                    if (beat_q != '0)
                        lfsr_d = lfsr_nxt;
                    if (last_beat) begin
                        cnt_d  = cnt_sat;
                        beat_d = '0;
                        gap_d  = '0;
                        if (GAP_CYCLES == 0)
                            state_d = after_pkt(cnt_sat, num_q, i_start);
                        else
                            state_d = S_GAP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST)
                    state_d = after_pkt(cnt_q, num_q, i_start);
                else
                    gap_d = gap_q + 1'b1;
            end
            S_DONE: begin
                if (!i_start) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            flit_q  <= '0;
            tx_q    <= 1'b0;
            cnt_q   <= '0;
            beat_q  <= '0;
            len_q   <= LEN_W'(1);
            gap_q   <= '0;
            lfsr_q  <= SEED;
            ptr_q   <= '0;
            dest_q  <= '0;
            src_q   <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            flit_q  <= flit_d;
            tx_q    <= tx_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            gap_q   <= gap_d;
            lfsr_q  <= lfsr_d;
            ptr_q   <= ptr_d;
            dest_q  <= dest_d;
            src_q   <= src_d;
            num_q   <= num_d;
        end
    end

    assign o_flit      = flit_q;
    assign o_transmit  = tx_q;
    assign o_pkt_count = cnt_q;
    assign o_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_done      = (state_q == S_DONE);

endmodule
